// File: rtl/kmat_mem_arbiter.sv
// ---------------------------------------------------------------------------
// kmat_mem_arbiter
//
// Shares one single-port K-matrix SRAM between the encode block (writer) and
// the decode block (reader). One side owns the SRAM at a time. A grant is held
// for a burst. After MAX_BURST accepted accesses, if the other side is
// waiting, the arbiter hands over through a one-cycle TURN bubble. That
// bubble lets the last read drain out of the SRAM's one-cycle read pipeline.
//
// Ports
//   i_clk, i_rst          clock, synchronous active-high reset
//   i_wr_req / o_wr_gnt   encode ownership request / registered grant
//   i_wr_en/addr/data     encode write strobe, address and data
//   i_rd_req / o_rd_gnt   decode ownership request / registered grant
//   i_rd_en/addr          decode read strobe and address
//   o_rd_data/o_rd_valid  read data (pass-through of i_ram_data) and strobe
//   o_ram_*               SRAM pins: ce_N (active-low), rdWr_N (1=read),
//                         addr, data
//   i_ram_data            SRAM read data, one-cycle registered latency
//   o_busy                arbiter not idle
//
// Optional build macro KMAT_ARB_STATS_EN adds these outputs:
//   o_wait_cycles [15:0]  cycles in which some requester waits; saturates
//   o_handovers   [7:0]   number of forced handovers (TURN entries); wraps
// ---------------------------------------------------------------------------
module kmat_mem_arbiter #(
    parameter int WIDTH      = 16,
    parameter int ADDR_WIDTH = 4,
    parameter int MAX_BURST  = 16
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_wr_req,
    output logic                  o_wr_gnt,
    input  logic                  i_wr_en,
    input  logic [ADDR_WIDTH-1:0] i_wr_addr,
    input  logic [WIDTH-1:0]      i_wr_data,
    input  logic                  i_rd_req,
    output logic                  o_rd_gnt,
    input  logic                  i_rd_en,
    input  logic [ADDR_WIDTH-1:0] i_rd_addr,
    output logic [WIDTH-1:0]      o_rd_data,
    output logic                  o_rd_valid,
    output logic                  o_ram_ce_N,
    output logic                  o_ram_rdWr_N,
    output logic [ADDR_WIDTH-1:0] o_ram_addr,
    output logic [WIDTH-1:0]      o_ram_data,
    input  logic [WIDTH-1:0]      i_ram_data,
`ifdef KMAT_ARB_STATS_EN
    output logic [15:0]           o_wait_cycles,
    output logic [7:0]            o_handovers,
`endif
    output logic                  o_busy
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_GNT_WR = 2'd1;
    localparam logic [1:0] ST_GNT_RD = 2'd2;
    localparam logic [1:0] ST_TURN   = 2'd3;

    localparam logic SRV_RD = 1'b0;
    localparam logic SRV_WR = 1'b1;

    localparam int              CNT_W   = $clog2(MAX_BURST + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BURST);

    logic [1:0]       state_q, state_d;
    logic             last_srv_q, last_srv_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] cnt_inc;
    logic             wr_gnt_q, wr_gnt_d;
    logic             rd_gnt_q, rd_gnt_d;
    logic             busy_q, busy_d;
    logic             rd_valid_q, rd_valid_d;
    logic             wr_access;
    logic             rd_access;

    // An access counts only when the strobe arrives while that side holds the
    // grant. Strobes from the other side are dropped.
    assign wr_access = (state_q == ST_GNT_WR) & i_wr_en;
    assign rd_access = (state_q == ST_GNT_RD) & i_rd_en;
    assign cnt_inc   = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);

    // Next-state logic
    always_comb begin
        state_d    = state_q;
        last_srv_d = last_srv_q;
        cnt_d      = cnt_q;

        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                // On a tie, the side that was not served last wins.
                if (i_wr_req && (!i_rd_req || last_srv_q == SRV_RD)) begin
                    state_d = ST_GNT_WR;
                end else if (i_rd_req) begin
                    state_d = ST_GNT_RD;
                end
            end
            ST_GNT_WR: begin
                if (wr_access) begin
                    cnt_d = cnt_inc;
                end
                // The limit is judged on the count that includes this cycle's
                // access. The grant therefore drops right after the
                // MAX_BURST-th access, not one cycle later.
                if (!i_wr_req) begin
                    state_d    = ST_IDLE;
                    last_srv_d = SRV_WR;
                end else if (cnt_d == CNT_MAX && i_rd_req) begin
                    state_d    = ST_TURN;
                    last_srv_d = SRV_WR;
                end
            end
            ST_GNT_RD: begin
                if (rd_access) begin
                    cnt_d = cnt_inc;
                end
                if (!i_rd_req) begin
                    state_d    = ST_IDLE;
                    last_srv_d = SRV_RD;
                end else if (cnt_d == CNT_MAX && i_wr_req) begin
                    state_d    = ST_TURN;
                    last_srv_d = SRV_RD;
                end
            end
            ST_TURN: begin
                cnt_d = '0;
                if (last_srv_q == SRV_WR) begin
                    state_d = i_rd_req ? ST_GNT_RD : ST_IDLE;
                end else begin
                    state_d = i_wr_req ? ST_GNT_WR : ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Grant and busy outputs are decoded from the next state and registered.
    // This keeps them glitch-free flops that line up with state_q.
    always_comb begin
        wr_gnt_d   = (state_d == ST_GNT_WR);
        rd_gnt_d   = (state_d == ST_GNT_RD);
        busy_d     = (state_d != ST_IDLE);
        rd_valid_d = rd_access;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q    <= ST_IDLE;
            last_srv_q <= SRV_RD;
            cnt_q      <= '0;
            wr_gnt_q   <= 1'b0;
            rd_gnt_q   <= 1'b0;
            busy_q     <= 1'b0;
            rd_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            last_srv_q <= last_srv_d;
            cnt_q      <= cnt_d;
            wr_gnt_q   <= wr_gnt_d;
            rd_gnt_q   <= rd_gnt_d;
            busy_q     <= busy_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    // SRAM pin mux. When no access is active, the pins sit at idle values
    // (deselected, read direction, zero address and zero data).
    always_comb begin
        o_ram_ce_N   = 1'b1;
        o_ram_rdWr_N = 1'b1;
        o_ram_addr   = '0;
        o_ram_data   = '0;
        if (wr_access) begin
            o_ram_ce_N   = 1'b0;
            o_ram_rdWr_N = 1'b0;
            o_ram_addr   = i_wr_addr;
            o_ram_data   = i_wr_data;
        end else if (rd_access) begin
            o_ram_ce_N   = 1'b0;
            o_ram_rdWr_N = 1'b1;
            o_ram_addr   = i_rd_addr;
        end
    end

    assign o_wr_gnt   = wr_gnt_q;
    assign o_rd_gnt   = rd_gnt_q;
    assign o_busy     = busy_q;
    assign o_rd_valid = rd_valid_q;
    assign o_rd_data  = i_ram_data;

`ifdef KMAT_ARB_STATS_EN
    logic [15:0] wait_cycles_q, wait_cycles_d;
    logic [7:0]  handovers_q, handovers_d;
    logic        any_wait;

    // A cycle counts once, even when both sides are waiting at the same time.
    assign any_wait = (i_wr_req & ~wr_gnt_q) | (i_rd_req & ~rd_gnt_q);

    always_comb begin
        wait_cycles_d = wait_cycles_q;
        handovers_d   = handovers_q;
        if (any_wait && wait_cycles_q != 16'hFFFF) begin
            wait_cycles_d = wait_cycles_q + 16'd1;
        end
        if (state_d == ST_TURN && state_q != ST_TURN) begin
            handovers_d = handovers_q + 8'd1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wait_cycles_q <= '0;
            handovers_q   <= '0;
        end else begin
            wait_cycles_q <= wait_cycles_d;
            handovers_q   <= handovers_d;
        end
    end

    assign o_wait_cycles = wait_cycles_q;
    assign o_handovers   = handovers_q;
`endif

endmodule

// File: doc/kmat_mem_arbiter.md
Name: kmat_mem_arbiter

Overview:
- Shares one single-port K-matrix SRAM between the encode block (write requester) and the decode block (read requester).
- Grants the SRAM to one requester at a time, holds the grant for a burst, and forces a handover after MAX_BURST accesses when the other side is waiting.
- Muxes the granted requester's controls onto the SRAM and tags returning read data with a valid strobe.
- Sits between the encode/decode datapaths and the encoded-K SRAM in the KEM top level.

Parameters:
- WIDTH, 16: SRAM word width in bits (the decode word size).
- ADDR_WIDTH, 4: SRAM address width in bits.
- MAX_BURST, 16: accepted accesses per grant before a forced handover when the other side is requesting; must be >= 1.

Ports:
- i_clk  in  1  system clock, all logic on the rising edge.
- i_rst  in  1  synchronous reset, active-high.
- i_wr_req  in  1  encode requests SRAM ownership.
- o_wr_gnt  out  1  encode owns the SRAM (registered).
- i_wr_en  in  1  write strobe; honoured only while o_wr_gnt=1.
- i_wr_addr  in  ADDR_WIDTH  write address.
- i_wr_data  in  WIDTH  write data.
- i_rd_req  in  1  decode requests SRAM ownership.
- o_rd_gnt  out  1  decode owns the SRAM (registered).
- i_rd_en  in  1  read strobe; honoured only while o_rd_gnt=1.
- i_rd_addr  in  ADDR_WIDTH  read address.
- o_rd_data  out  WIDTH  read data, passed through from i_ram_data.
- o_rd_valid  out  1  o_rd_data is valid for the read accepted on the previous cycle.
- o_ram_ce_N  out  1  SRAM chip enable, active-low.
- o_ram_rdWr_N  out  1  SRAM direction: 1 = read, 0 = write.
- o_ram_addr  out  ADDR_WIDTH  SRAM address.
- o_ram_data  out  WIDTH  SRAM write data.
- i_ram_data  in  WIDTH  SRAM read data; the SRAM has 1-cycle registered read latency.
- o_busy  out  1  the FSM is not in IDLE.

Behaviour:
- Reset values: o_wr_gnt=0, o_rd_gnt=0, o_rd_valid=0, o_busy=0, o_ram_ce_N=1, o_ram_rdWr_N=1, o_ram_addr=0, o_ram_data=0.
- States: IDLE, GNT_WR, GNT_RD, TURN. A 1-bit last_srv register resets to RD, so a write wins the first tie.
- IDLE:
  - wr_req only -> GNT_WR.
  - rd_req only -> GNT_RD.
  - Both -> the side not equal to last_srv.
  - Grant is visible the cycle after the request is sampled (1-cycle grant latency).
- GNT_x:
  - SRAM pins are combinationally muxed from the granted requester.
  - o_ram_ce_N = ~x_en.
  - o_ram_rdWr_N = 1 for RD; o_ram_rdWr_N = ~wr_en for WR.
  - When x_en=0: ce_N=1, addr=0, data=0.
  - The non-granted requester's en/addr/data are ignored; its accesses are dropped, not queued.
- Burst counter:
  - Cleared on entry to each grant state.
  - Increments on each accepted access and saturates at MAX_BURST.
- Leaving GNT_x:
  - x_req=0 -> IDLE (if the other side is requesting, it is granted through IDLE on the next cycle).
  - Counter==MAX_BURST and the other side requesting -> TURN.
  - Otherwise stay.
  - last_srv is set to x on exit.
- TURN:
  - Exactly one cycle with both grants low and the SRAM idle, to drain the read pipeline.
  - Then enter the grant state of the side not equal to last_srv, if it still requests; otherwise IDLE.
- o_rd_valid is a register: 1 on the cycle after o_rd_gnt & i_rd_en was sampled, otherwise 0.
- o_rd_data = i_ram_data, unregistered.
- Write with i_wr_en held continuously in GNT_WR: one SRAM write per cycle, no bubbles.
- Simultaneous requester drop and counter limit: the drop takes priority, going to IDLE.
- Reset mid-burst:
  - All state and outputs return to reset values at that edge.
  - An in-flight read produces no o_rd_valid.
  - last_srv returns to RD.

Optional Feature:
- Macro KMAT_ARB_STATS_EN.
- Defined:
  - Adds output o_wait_cycles [15:0]: counts cycles where a requester's req=1 and its grant=0; saturates at 16'hFFFF.
  - Adds output o_handovers [7:0]: counts TURN entries; wraps.
  - Both counters clear on i_rst.
- Undefined: neither port nor counter exists; the rest of the behaviour is identical.

Test Plan:
- Reset, then wr_req=1 with 16 writes of data=addr*3 -> o_wr_gnt high 1 cycle after req; ce_N=0 and rdWr_N=0 for 16 consecutive cycles; SRAM holds 0,3,..,45.
- Then rd_req=1 with reads of addr 0..15 -> o_rd_valid follows each read by 1 cycle; o_rd_data = 0,3,..,45.
- wr_req and rd_req rise together from reset -> WR granted first. After the WR drop -> IDLE -> RD granted; a second simultaneous tie -> RD wins (last_srv=WR).
- MAX_BURST=4, WR streaming, rd_req held -> after 4 writes a 1-cycle TURN with both grants 0, then o_rd_gnt=1. With KMAT_ARB_STATS_EN: o_handovers=1.
- rd_en asserted while o_rd_gnt=0 -> ce_N stays 1 and no o_rd_valid.
- i_rst pulsed the cycle after a read issue -> o_rd_valid=0, all grants 0, o_busy=0 the next cycle.
